// File: rtl/decode_issue_stage.sv
// Instruction-decode stage: IF/ID latch, RAW hazard resolution, registered ID/EX bundle.
// Optional macro ID_FWD_EN enables EX/MEM operand forwarding; without it, hazards stall.
module decode_issue_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_ready,
  output logic [ADDR_W-1:0]  o_src1,
  output logic [ADDR_W-1:0]  o_src2,
  input  logic [DATA_W-1:0]  i_reg1,
  input  logic [DATA_W-1:0]  i_reg2,
  input  logic               i_ex_wr_en,
  input  logic               i_ex_is_load,
  input  logic [ADDR_W-1:0]  i_ex_dest,
  input  logic [DATA_W-1:0]  i_ex_result,
  input  logic               i_mem_wr_en,
  input  logic [ADDR_W-1:0]  i_mem_dest,
  input  logic [DATA_W-1:0]  i_mem_result,
  input  logic               i_flush,
  input  logic               i_ex_ready,
  output logic               o_valid,
  output logic [5:0]         o_opcode,
  output logic [ADDR_W-1:0]  o_dest,
  output logic [DATA_W-1:0]  o_op1,
  output logic [DATA_W-1:0]  o_op2,
  output logic [DATA_W-1:0]  o_imm,
  output logic               o_wr_en,
  output logic               o_is_load,
  output logic [PC_W-1:0]    o_pc
);

  logic               ifid_v_reg;
  logic [INSTR_W-1:0] ifid_instr_reg;
  logic [PC_W-1:0]    ifid_pc_reg;

  logic               valid_reg;
  logic [5:0]         opcode_reg;
  logic [ADDR_W-1:0]  dest_reg;
  logic [DATA_W-1:0]  op1_reg, op2_reg, imm_reg;
  logic               wr_en_reg, is_load_reg;
  logic [PC_W-1:0]    pc_reg;

  logic [1:0]         cls;
  logic [ADDR_W-1:0]  src [2];
  logic [DATA_W-1:0]  reg_data [2];
  logic [DATA_W-1:0]  operand [2];
  logic [1:0]         used, stall_hit;
  logic [DATA_W-1:0]  imm_next;
  logic               hazard, issue, accept;

  assign cls         = ifid_instr_reg[31:30];
  assign src[0]      = ifid_instr_reg[20:16];
  assign src[1]      = ifid_instr_reg[15:11];
  assign reg_data[0] = i_reg1;
  assign reg_data[1] = i_reg2;
  assign used[0]     = 1'b1;
  assign used[1]     = (cls == 2'b00) || (cls == 2'b11);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic ex_hit, mem_hit;
      assign ex_hit  = used[gi] && i_ex_wr_en && (i_ex_dest == src[gi]);
      assign mem_hit = used[gi] && i_mem_wr_en && (i_mem_dest == src[gi]);
`ifdef ID_FWD_EN
      // A load in EX has no data yet; it can only be forwarded once it reaches MEM.
      assign stall_hit[gi] = ex_hit && i_ex_is_load;
      assign operand[gi]   = (ex_hit && !i_ex_is_load) ? i_ex_result :
                             mem_hit                   ? i_mem_result : reg_data[gi];
`else
      assign stall_hit[gi] = ex_hit || mem_hit;
      assign operand[gi]   = reg_data[gi];
`endif
    end
  endgenerate

`ifndef ID_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{i_ex_result, i_mem_result, i_ex_is_load};
`endif

  assign hazard  = ifid_v_reg && (|stall_hit);
  assign issue   = ifid_v_reg && !hazard && (!valid_reg || i_ex_ready);
  assign o_ready = !i_flush && (!ifid_v_reg || issue);
  assign accept  = i_valid && o_ready;

  always_comb begin
    imm_next = '0;
    case (cls)
      2'b01, 2'b10: imm_next = DATA_W'(ifid_instr_reg[15:0]);
      2'b11:        imm_next = DATA_W'($signed(ifid_instr_reg[10:0]));
      default:      imm_next = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ifid_v_reg     <= 1'b0;
      ifid_instr_reg <= '0;
      ifid_pc_reg    <= '0;
    end else begin
      if (i_flush)     ifid_v_reg <= 1'b0;
      else if (accept) ifid_v_reg <= 1'b1;
      else if (issue)  ifid_v_reg <= 1'b0;
      if (accept) begin
        ifid_instr_reg <= i_instr;
        ifid_pc_reg    <= i_pc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_reg   <= 1'b0;
      opcode_reg  <= '0;
      dest_reg    <= '0;
      op1_reg     <= '0;
      op2_reg     <= '0;
      imm_reg     <= '0;
      wr_en_reg   <= 1'b0;
      is_load_reg <= 1'b0;
      pc_reg      <= '0;
    end else if (i_flush) begin
      valid_reg <= 1'b0;
    end else if (issue) begin
      valid_reg   <= 1'b1;
      opcode_reg  <= ifid_instr_reg[31:26];
      dest_reg    <= ifid_instr_reg[25:21];
      op1_reg     <= operand[0];
      op2_reg     <= operand[1];
      imm_reg     <= imm_next;
      wr_en_reg   <= (cls != 2'b11);
      is_load_reg <= (cls == 2'b10);
      pc_reg      <= ifid_pc_reg;
    end else if (i_ex_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign o_src1    = src[0];
  assign o_src2    = src[1];
  assign o_valid   = valid_reg;
  assign o_opcode  = opcode_reg;
  assign o_dest    = dest_reg;
  assign o_op1     = op1_reg;
  assign o_op2     = op2_reg;
  assign o_imm     = imm_reg;
  assign o_wr_en   = wr_en_reg;
  assign o_is_load = is_load_reg;
  assign o_pc      = pc_reg;

endmodule
